interleaver_rd_sched: RTL and testbench



---
 rtl/interleaver_rd_sched.sv | 126 ++++++++++++
 tb/tb_interleaver_rd_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/interleaver_rd_sched.sv
// Read-side scheduler for the interleaver output stage: walks lane select and
// row address so a frame leaves column-interleaved, one byte per accepted beat.
module interleaver_rd_sched #(
  parameter int N_LANES = 12,
  parameter int SEL_W   = 4,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(N_LANES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sel_d   = '0;
          addr_d  = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (valid_q && out_ready) begin
          if (sel_q == SEL_MAX) begin
            sel_d = '0;
            if (addr_q == ADDR_MAX) begin
              state_d = S_DONE;
              addr_d  = '0;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over start and over the beat advance, and suppresses done.
    if (abort) begin
      state_d = S_IDLE;
      sel_d   = '0;
      addr_d  = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end

    // last is registered from the next-state beat, so it never depends on out_ready combinationally.
    last_d = valid_d && (sel_d == SEL_MAX) && (addr_d == ADDR_MAX);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel       = sel_q;
  assign rd_addr   = addr_q;
  assign out_valid = valid_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_interleaver_rd_sched.sv
// Directed bench for interleaver_rd_sched: full frames, backpressure, ignored
// starts, abort, async reset mid-frame and random-ready back-to-back frames.
module tb_interleaver_rd_sched;

  localparam int N_LANES = 12;
  localparam int SEL_W   = 4;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int BEATS   = N_LANES * DEPTH;
  localparam int BUDGET  = 4000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] rd_addr;
  logic              out_valid;
  logic              out_ready;
  logic              last;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  interleaver_rd_sched #(
    .N_LANES(N_LANES),
    .SEL_W  (SEL_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .sel      (sel),
    .rd_addr  (rd_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .last     (last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and settle past the edge before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"},   32'(sel),       32'd0);
    check({tag, "_addr"},  32'(rd_addr),   32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"},  32'(last),      32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called on the cycle where the first beat must already be valid. Every
  // cycle is checked against the expected beat index; on completion the DONE
  // cycle and the following IDLE cycle are checked, leaving the bench there.
  task automatic run_frame(input bit rand_rdy, input int stall_beat, input int start_beat,
                           input int abort_beat, input int rst_beat, input bit start_in_done);
    int exp_beat   = 0;
    int cyc        = 0;
    int stall_left = 3;
    while (exp_beat < BEATS && cyc < BUDGET) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exp_beat == stall_beat && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      start = (exp_beat == start_beat);
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_sel",   32'(sel),       32'(exp_beat % N_LANES));
      check("beat_addr",  32'(rd_addr),   32'(exp_beat / N_LANES));
      check("beat_last",  32'(last),      32'(exp_beat == BEATS - 1));
      check("beat_busy",  32'(busy),      32'd1);
      check("beat_done",  32'(done),      32'd0);
      check("sel_range",  32'(int'(sel) <= N_LANES - 1), 32'd1);
      if (exp_beat == abort_beat) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort");
        return;
      end
      if (exp_beat == rst_beat) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        return;
      end
      if (out_ready) exp_beat++;
      tick();
      cyc++;
    end
    start = 1'b0;
    check("frame_in_budget", 32'(cyc < BUDGET), 32'd1);
    check("done_pulse", 32'(done),      32'd1);
    check("done_busy",  32'(busy),      32'd1);
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_last",  32'(last),      32'd0);
    start = start_in_done;
    tick();
    start = 1'b0;
    check("post_done",  32'(done),      32'd0);
    check("post_busy",  32'(busy),      32'd0);
    check("post_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("idle_after_reset");

    // Full frame with out_ready tied high, then IDLE stays quiet without start.
    pulse_start();
    run_frame(1'b0, -1, -1, -1, -1, 1'b0);
    tick();
    check("idle_no_start", 32'(out_valid), 32'd0);

    // Stall 3 cycles at (2,11), start pulses at beat 50 and in DONE are ignored.
    pulse_start();
    run_frame(1'b0, 2 * N_LANES + 11, 50, -1, -1, 1'b1);
    tick();
    check("no_queued_start_valid", 32'(out_valid), 32'd0);
    check("no_queued_start_busy",  32'(busy),      32'd0);

    // Abort at (7,4): no done pulse afterwards, then a clean restart at (0,0).
    pulse_start();
    run_frame(1'b0, -1, -1, 7 * N_LANES + 4, -1, 1'b0);
    repeat (3) begin
      tick();
      check("abort_no_done",  32'(done),      32'd0);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    pulse_start();
    run_frame(1'b0, -1, -1, -1, -1, 1'b0);

    // abort together with start in IDLE keeps the block idle.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_idle("abort_start_idle");

    // Asynchronous reset at (3,5), then 10 quiet cycles after release.
    pulse_start();
    run_frame(1'b0, -1, -1, -1, 3 * N_LANES + 5, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      tick();
      check_idle("hold_idle");
    end

    // Three back-to-back frames with random ready; each restart is in the IDLE cycle after DONE.
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b1, -1, -1, -1, -1, 1'b0);
      if (f < 2) pulse_start();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
